// File: rtl/io_bus_arbiter_if.sv
// Requester handshake and peripheral bus bundle for the two-master I/O bus arbiter.
// Requesters hold req with addr/we/wdata stable until their one-cycle ack; the arbiter then owns the bus.
interface io_bus_arbiter_if;
  logic        req0;
  logic        req1;
  logic [63:0] addr0;
  logic [63:0] addr1;
  logic        we0;
  logic        we1;
  logic [63:0] wdata0;
  logic [63:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [63:0] rdata;
  logic        err;
  logic        busy;
  logic [63:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [63:0] bus_wdata;
  logic [63:0] bus_data;

  modport master (
    output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, bus_data,
    input  ack0, ack1, rdata, err, busy, bus_address, bus_read, bus_write, bus_wdata
  );

  modport slave (
    input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, bus_data,
    output ack0, ack1, rdata, err, busy, bus_address, bus_read, bus_write, bus_wdata
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter for two bus requesters: address setup, held strobe, capture and one-cycle ACK.
// Device ID lives in address bits [63:56]; IDs outside 1..NUM_DEV complete at once with ERR and no bus cycle.
module io_bus_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int NUM_DEV     = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  io_bus_arbiter_if.slave   bus,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);
  localparam logic [7:0] MAX_ID   = 8'(NUM_DEV);

  state_t      state;
  logic        last;
  logic        we_r;
  logic [3:0]  cnt;

  logic        grant;
  logic [63:0] g_addr;
  logic [63:0] g_wdata;
  logic        g_we;
  logic [7:0]  g_id;
  logic        g_valid;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant = bus.req1;
    if (bus.req0 && bus.req1) grant = ~last;
    g_addr  = grant ? bus.addr1  : bus.addr0;
    g_wdata = grant ? bus.wdata1 : bus.wdata0;
    g_we    = grant ? bus.we1    : bus.we0;
    g_id    = g_addr[63:56];
    g_valid = (g_id != 8'd0) && (g_id <= MAX_ID);
  end

  assign fsm_state = state;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state           <= IDLE;
      last            <= 1'b1;
      we_r            <= 1'b0;
      cnt             <= 4'd0;
      bus.ack0        <= 1'b0;
      bus.ack1        <= 1'b0;
      bus.rdata       <= 64'd0;
      bus.err         <= 1'b0;
      bus.busy        <= 1'b0;
      bus.bus_address <= 64'd0;
      bus.bus_read    <= 1'b0;
      bus.bus_write   <= 1'b0;
      bus.bus_wdata   <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            last     <= grant;
            bus.busy <= 1'b1;
            if (g_valid) begin
              state           <= ADDR;
              bus.bus_address <= g_addr;
              bus.bus_wdata   <= g_wdata;
              we_r            <= g_we;
            end else begin
              // Decode error: finish immediately without touching the bus.
              state     <= RESP;
              bus.rdata <= 64'd0;
              bus.err   <= 1'b1;
              bus.ack0  <= ~grant;
              bus.ack1  <= grant;
            end
          end
        end
        ADDR: begin
          state         <= WAIT;
          cnt           <= 4'd0;
          bus.bus_read  <= ~we_r;
          bus.bus_write <= we_r;
        end
        WAIT: begin
          if (cnt == LAST_CNT) begin
            state         <= RESP;
            bus.bus_read  <= 1'b0;
            bus.bus_write <= 1'b0;
            bus.err       <= 1'b0;
            bus.ack0      <= ~last;
            bus.ack1      <= last;
            if (!we_r) bus.rdata <= bus.bus_data;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          state           <= IDLE;
          bus.ack0        <= 1'b0;
          bus.ack1        <= 1'b0;
          bus.err         <= 1'b0;
          bus.busy        <= 1'b0;
          bus.bus_address <= 64'd0;
          bus.bus_wdata   <= 64'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
